// File: rtl/xmit_frame_sched.sv
// Transmit frame scheduler: picks the next frame from the hi/lo queues (strict priority
// with a starvation guard), streams it with valid/ready, drops bad lengths, enforces the IFG.
module xmit_frame_sched #(
    parameter int HI_BURST   = 4,
    parameter int MIN_LEN    = 64,
    parameter int MAX_LEN    = 1518,
    parameter int IFG_CYCLES = 12
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        hi_ctrl_empty,
    input  logic [23:0] hi_ctrl_q,
    output logic        hi_ctrl_rd,
    input  logic [7:0]  hi_data_q,
    output logic        hi_data_rd,
    input  logic        lo_ctrl_empty,
    input  logic [23:0] lo_ctrl_q,
    output logic        lo_ctrl_rd,
    input  logic [7:0]  lo_data_q,
    output logic        lo_data_rd,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        tx_sof,
    output logic        tx_eof,
    input  logic        tx_ready,
    output logic        m_discard_en,
    output logic        cur_hi,
    output logic        busy
);

    localparam int SW = $clog2(HI_BURST + 1);
    localparam int GW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [SW-1:0] STREAK_MAX = SW'(HI_BURST);
    localparam logic [GW-1:0] GAP_LAST   = GW'(IFG_CYCLES - 1);
    localparam logic [11:0]   LEN_MIN    = 12'(MIN_LEN);
    localparam logic [11:0]   LEN_MAX    = 12'(MAX_LEN);

    typedef enum logic [1:0] {IDLE, XFER, DROP, GAP} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [11:0]     r_cnt;
    logic [11:0]     r_len;
    logic            r_cur_hi;
    logic [SW-1:0]   r_streak;
    logic [GW-1:0]   r_gap;

    logic            w_hi_req;
    logic            w_lo_req;
    logic            w_grant;
    logic            w_pick_hi;
    logic [11:0]     w_new_len;
    logic            w_len_ok;
    logic            w_pop;
    logic            w_last;
    logic            w_unused;

    assign w_unused  = ^{hi_ctrl_q[23:12], lo_ctrl_q[23:12]};
    assign w_hi_req  = !hi_ctrl_empty;
    assign w_lo_req  = !lo_ctrl_empty;
    // Gated by reset so no pop can escape while the FIFOs are being flushed.
    assign w_grant   = reset && (r_state == IDLE) && (w_hi_req || w_lo_req);
    assign w_pick_hi = w_hi_req && (!w_lo_req || (r_streak < STREAK_MAX));
    assign w_new_len = w_pick_hi ? hi_ctrl_q[11:0] : lo_ctrl_q[11:0];
    assign w_len_ok  = (w_new_len >= LEN_MIN) && (w_new_len <= LEN_MAX);
    assign w_pop     = (r_state == DROP) || ((r_state == XFER) && tx_ready);
    assign w_last    = w_pop && (r_cnt == 12'd1);

    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_grant) begin
                    if (w_new_len == 12'd0) begin
                        w_next = GAP;
                    end else if (w_len_ok) begin
                        w_next = XFER;
                    end else begin
                        w_next = DROP;
                    end
                end
            end
            XFER, DROP: begin
                if (w_last) begin
                    w_next = GAP;
                end
            end
            GAP: begin
                if (r_gap == GAP_LAST) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Byte counter, source latch, starvation streak and gap timer.
    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            r_cnt    <= '0;
            r_len    <= '0;
            r_cur_hi <= 1'b0;
            r_streak <= '0;
            r_gap    <= '0;
        end else begin
            if (w_grant) begin
                r_cnt    <= w_new_len;
                r_len    <= w_new_len;
                r_cur_hi <= w_pick_hi;
                if (w_pick_hi && w_lo_req) begin
                    r_streak <= (r_streak == STREAK_MAX) ? r_streak : r_streak + 1'b1;
                end else begin
                    r_streak <= '0;
                end
            end else if (w_pop) begin
                r_cnt <= r_cnt - 12'd1;
            end
            r_gap <= (r_state == GAP) ? r_gap + 1'b1 : '0;
        end
    end

    always_comb begin
        hi_ctrl_rd   = 1'b0;
        lo_ctrl_rd   = 1'b0;
        hi_data_rd   = 1'b0;
        lo_data_rd   = 1'b0;
        tx_data      = 8'h00;
        tx_valid     = 1'b0;
        tx_sof       = 1'b0;
        tx_eof       = 1'b0;
        m_discard_en = 1'b0;
        unique case (r_state)
            IDLE: begin
                hi_ctrl_rd   = w_grant && w_pick_hi;
                lo_ctrl_rd   = w_grant && !w_pick_hi;
                m_discard_en = w_grant && (w_new_len == 12'd0);
            end
            XFER: begin
                tx_valid   = 1'b1;
                tx_data    = r_cur_hi ? hi_data_q : lo_data_q;
                tx_sof     = (r_cnt == r_len);
                tx_eof     = (r_cnt == 12'd1);
                hi_data_rd = r_cur_hi && tx_ready;
                lo_data_rd = !r_cur_hi && tx_ready;
            end
            DROP: begin
                hi_data_rd   = r_cur_hi;
                lo_data_rd   = !r_cur_hi;
                m_discard_en = (r_cnt == r_len);
            end
            default: begin
            end
        endcase
    end

    assign cur_hi = r_cur_hi;
    assign busy   = (r_state != IDLE);

endmodule
